sha256_msg_sched: RTL and testbench
===================================

Name: sha256_msg_sched

Overview:
Consumer end of the message-buffer block interface. Accepts one 512-bit padded block through the block_ready/parser_ready handshake. Streams the 64 message-schedule words W0..W63 to the compression core over a valid/ready word interface. W0..W15 come straight from the block; W16..W63 are expanded on the fly from a 16-word sliding window.

Parameters:
WORD_W, 32, schedule word width (fixed by SHA-256; not for override)
BLOCK_W, 512, block width (= 16*WORD_W)
NUM_WORDS, 64, schedule words emitted per block

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-low reset (0 = reset)
block_in  input  512  padded block from message buffer; bits [511:480] = W0 (big-endian words)
block_ready  input  1  message buffer has a valid block on block_in
parser_ready  output  1  this block can accept a block this cycle
w_out  output  32  current schedule word
w_valid  output  1  w_out/w_index valid
w_ready  input  1  compression core accepts word this cycle
w_index  output  6  index t of w_out (0..63)
block_done  output  1  one-cycle pulse: W63 transferred

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; parser_ready=1 combinationally in IDLE; w_valid=0, w_out=0, w_index=0, block_done=0; window cleared. An in-flight block is discarded with no done pulse.
- States: IDLE, STREAM.
- IDLE: parser_ready=1. Accept occurs when block_ready && parser_ready at the clock edge.
  - On accept: window[0..15] <= W0..W15 from block_in; w_index<=0; w_valid<=1; state->STREAM.
  - First word (W0) is valid the cycle after accept.
- STREAM: parser_ready=0 (except under the optional feature). block_ready is ignored; the producer holds it.
  - w_out = window[0] (= W[t]), registered.
  - Transfer occurs on w_valid && w_ready. On each transfer:
    - window shifts down one word.
    - window[15] <= σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32. This is W[t+16] relative to the current t.
    - w_index <= w_index+1.
  - w_ready=0: w_out, w_index and window hold; w_valid stays 1; no bubbles inserted.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3; σ1(x) = ROTR17 ^ ROTR19 ^ SHR10. All adds are 32-bit with carry discarded.
  - Transfer at w_index==63: block_done=1 next cycle (pulse); w_valid<=0; state->IDLE; w_index<=0.
  - Expansion past index 63 is never emitted; window content after 63 is don't-care.
- Throughput without the optional feature: 64 transfer cycles + 1 accept cycle per block, i.e. 65 cycles/block with w_ready tied high.
- block_ready and w_ready are sampled only at edges; no combinational path from block_in to any output.

Optional Feature:
SHA256_SCHED_B2B_EN
- Defined: parser_ready is also asserted in STREAM when w_index==63 && w_valid && w_ready (combinational from w_ready).
  - If block_ready is high in that cycle, W63 transfers and the new block loads in the same edge. State stays STREAM; w_index<=0; w_valid stays 1.
  - block_done still pulses the next cycle.
  - Result: 64 cycles/block back-to-back.
- Undefined: parser_ready = (state==IDLE) only, giving one idle cycle between blocks.

Decomposition:
- Package sha256_pkg:
  - WORD_W, BLOCK_W, NUM_WORDS constants
  - sched_state_t enum {IDLE, STREAM}
  - functions small_sigma0 and small_sigma1
- Shared by the later compression-core work. No sub-module; the window plus expansion adder stays in one module.

Test Plan:
- "abc" block (0x61626380, 13 zero words, 0x00000018), w_ready=1 → W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W63=0x12B1EDEB; block_done pulses one cycle after W63; 64 words total.
- Same block, w_ready toggled pseudo-randomly (50%) → identical word sequence; w_out/w_index stable while w_ready=0.
- block_ready pulsed while in STREAM at t=20 → ignored; parser_ready=0; sequence unchanged.
- rst=0 asserted at w_index=30 → next cycle w_valid=0, parser_ready=1, no block_done; a re-sent block restarts at W0.
- Two blocks offered back-to-back with block_ready held → without SHA256_SCHED_B2B_EN, a 1-cycle gap with w_valid=0; with it defined, W0 of block 2 immediately follows W63 of block 1.
- All-zero block → all 64 words 0x00000000; all-ones block → W16=σ1(0xFFFFFFFF)+0xFFFFFFFF+σ0(0xFFFFFFFF)+0xFFFFFFFF, checked against the reference model.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, schedule state encoding and the small-sigma
// functions used by the message scheduler (and later the compression core).
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int BLOCK_W   = 512;
    localparam int NUM_WORDS = 64;

    typedef enum logic {
        IDLE,
        STREAM
    } sched_state_t;

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: takes one 512-bit padded block and streams
// W0..W63 over a valid/ready word interface, expanding W16..W63 from a
// 16-word sliding window as words are consumed.
// Optional build macro SHA256_SCHED_B2B_EN: accept the next block in the
// same cycle W63 transfers, removing the idle cycle between blocks.
//
// state  | meaning
// IDLE   | waiting for a block; parser_ready=1
// STREAM | emitting W[w_index] from window[0]
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BLOCK_W-1:0]   block_in,
    input  logic                 block_ready,
    output logic                 parser_ready,
    output logic [WORD_W-1:0]    w_out,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [5:0]           w_index,
    output logic                 block_done
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

    sched_state_t      state_q, state_d;
    logic [WORD_W-1:0] window_q [16];
    logic [WORD_W-1:0] window_d [16];
    logic [5:0]        w_index_q, w_index_d;
    logic              w_valid_q, w_valid_d;
    logic              block_done_q, block_done_d;

    logic              accept;
    logic              xfer;
    logic [WORD_W-1:0] new_word;

    // Handshake decode and next-state / window update
    always_comb begin
        state_d      = state_q;
        window_d     = window_q;
        w_index_d    = w_index_q;
        w_valid_d    = w_valid_q;
        block_done_d = 1'b0;

`ifdef SHA256_SCHED_B2B_EN
        parser_ready = (state_q == IDLE) ||
                       ((state_q == STREAM) && (w_index_q == LAST_IDX) && w_valid_q && w_ready);
`else
        parser_ready = (state_q == IDLE);
`endif

        accept   = block_ready && parser_ready;
        xfer     = w_valid_q && w_ready;
        // W[t+16] relative to the word currently in window[0]
        new_word = small_sigma1(window_q[14]) + window_q[9]
                 + small_sigma0(window_q[1]) + window_q[0];

        if (xfer) begin
            for (int i = 0; i < 15; i++) begin
                window_d[i] = window_q[i+1];
            end
            window_d[15] = new_word;
            w_index_d    = w_index_q + 6'd1;
            if (w_index_q == LAST_IDX) begin
                block_done_d = 1'b1;
                w_valid_d    = 1'b0;
                state_d      = IDLE;
                w_index_d    = 6'd0;
            end
        end

        // A same-edge accept (back-to-back build) overrides the end-of-block return
        if (accept) begin
            for (int i = 0; i < 16; i++) begin
                window_d[i] = block_in[BLOCK_W-1-WORD_W*i -: WORD_W];
            end
            w_index_d = 6'd0;
            w_valid_d = 1'b1;
            state_d   = STREAM;
        end
    end

    // State, window and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            w_index_q    <= 6'd0;
            w_valid_q    <= 1'b0;
            block_done_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                window_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            w_index_q    <= w_index_d;
            w_valid_q    <= w_valid_d;
            block_done_q <= block_done_d;
            for (int i = 0; i < 16; i++) begin
                window_q[i] <= window_d[i];
            end
        end
    end

    assign w_out      = window_q[0];
    assign w_valid    = w_valid_q;
    assign w_index    = w_index_q;
    assign block_done = block_done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed testbench for sha256_msg_sched with an independent SHA-256
// schedule reference model and hand-computed anchor words.
module tb_sha256_msg_sched;

    logic         clk;
    logic         rst;
    logic [511:0] block_in;
    logic         block_ready;
    logic         parser_ready;
    logic [31:0]  w_out;
    logic         w_valid;
    logic         w_ready;
    logic [5:0]   w_index;
    logic         block_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];
    int got_n, stall_viol, pr_viol, pr_seen, idx_viol, early_done, lat, cap_cycles;
    logic done_now, valid_after, done_after;

    localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_ZERO = '0;
    localparam logic [511:0] BLK_ONES = '1;

    sha256_msg_sched dut (
        .clk          (clk),
        .rst          (rst),
        .block_in     (block_in),
        .block_ready  (block_ready),
        .parser_ready (parser_ready),
        .w_out        (w_out),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_index      (w_index),
        .block_done   (block_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic compute_model(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) exp_w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
    endtask

    // Offers one block, then records transferred words and protocol observations.
    task automatic capture(input logic [511:0] blk, input bit rand_ready, input int pulse_at);
        int cyc;
        logic prev_stall;
        logic [31:0] prev_w;
        logic [5:0] prev_i;
        got_n = 0; stall_viol = 0; pr_viol = 0; pr_seen = 0; idx_viol = 0;
        early_done = 0; lat = -1;
        @(negedge clk);
        block_in = blk; block_ready = 1'b1; w_ready = 1'b0;
        @(negedge clk);
        block_ready = 1'b0;
        prev_stall = 1'b0; prev_w = '0; prev_i = '0; cyc = 0;
        while (got_n < 64 && cyc < 2000) begin
            if (prev_stall && (w_out !== prev_w || w_index !== prev_i || w_valid !== 1'b1))
                stall_viol++;
            if (block_done !== 1'b0) early_done++;
            if (lat < 0 && w_valid === 1'b1) lat = cyc;
            if (pulse_at >= 0 && got_n == pulse_at && w_valid === 1'b1) begin
                block_ready = 1'b1;
                block_in = ~blk;
                pr_seen++;
                if (parser_ready !== 1'b0) pr_viol++;
            end else begin
                block_ready = 1'b0;
            end
            w_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (w_valid === 1'b1 && w_ready) begin
                if (w_index !== got_n[5:0]) idx_viol++;
                got_w[got_n] = w_out;
                got_n++;
            end
            prev_stall = (w_valid === 1'b1) && !w_ready;
            prev_w = w_out;
            prev_i = w_index;
            @(negedge clk);
            cyc++;
        end
        cap_cycles = cyc;
        w_ready = 1'b0; block_ready = 1'b0;
        done_now = block_done;
        valid_after = w_valid;
        @(negedge clk);
        done_after = block_done;
    endtask

    task automatic test_reset();
        rst = 1'b0; block_ready = 1'b0; w_ready = 1'b0; block_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL reset_w_valid: got %b expected 0", w_valid); end
        checks++; if (w_out !== 32'h0) begin errors++; $display("FAIL reset_w_out: got %h expected 00000000", w_out); end
        checks++; if (w_index !== 6'd0) begin errors++; $display("FAIL reset_w_index: got %0d expected 0", w_index); end
        checks++; if (block_done !== 1'b0) begin errors++; $display("FAIL reset_block_done: got %b expected 0", block_done); end
        checks++; if (parser_ready !== 1'b1) begin errors++; $display("FAIL reset_parser_ready: got %b expected 1", parser_ready); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abc();
        compute_model(BLK_ABC);
        capture(BLK_ABC, 1'b0, -1);
        checks++; if (got_n != 64) begin errors++; $display("FAIL abc_count: got %0d expected 64", got_n); end
        checks++; if (lat != 0) begin errors++; $display("FAIL abc_first_latency: got %0d expected 0", lat); end
        checks++; if (cap_cycles != 64) begin errors++; $display("FAIL abc_cycles: got %0d expected 64", cap_cycles); end
        checks++; if (got_w[0] !== 32'h61626380) begin errors++; $display("FAIL abc_W0: got %h expected 61626380", got_w[0]); end
        checks++; if (got_w[15] !== 32'h00000018) begin errors++; $display("FAIL abc_W15: got %h expected 00000018", got_w[15]); end
        checks++; if (got_w[16] !== 32'h61626380) begin errors++; $display("FAIL abc_W16: got %h expected 61626380", got_w[16]); end
        checks++; if (got_w[17] !== 32'h000F0000) begin errors++; $display("FAIL abc_W17: got %h expected 000f0000", got_w[17]); end
        checks++; if (got_w[18] !== 32'h7DA86405) begin errors++; $display("FAIL abc_W18: got %h expected 7da86405", got_w[18]); end
        checks++; if (got_w[63] !== 32'h12B1EDEB) begin errors++; $display("FAIL abc_W63: got %h expected 12b1edeb", got_w[63]); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (got_w[t] !== exp_w[t]) begin errors++; $display("FAIL abc_word[%0d]: got %h expected %h", t, got_w[t], exp_w[t]); end
        end
        checks++; if (idx_viol != 0) begin errors++; $display("FAIL abc_index: got %0d bad indices expected 0", idx_viol); end
        checks++; if (early_done != 0) begin errors++; $display("FAIL abc_early_done: got %0d expected 0", early_done); end
        checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL abc_done_pulse: got %b expected 1", done_now); end
        checks++; if (valid_after !== 1'b0) begin errors++; $display("FAIL abc_valid_after: got %b expected 0", valid_after); end
        checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL abc_done_width: got %b expected 0", done_after); end
    endtask

    task automatic test_random_ready();
        compute_model(BLK_ABC);
        capture(BLK_ABC, 1'b1, -1);
        checks++; if (got_n != 64) begin errors++; $display("FAIL rnd_count: got %0d expected 64", got_n); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (got_w[t] !== exp_w[t]) begin errors++; $display("FAIL rnd_word[%0d]: got %h expected %h", t, got_w[t], exp_w[t]); end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL rnd_stall_hold: got %0d changes expected 0", stall_viol); end
        checks++; if (idx_viol != 0) begin errors++; $display("FAIL rnd_index: got %0d bad indices expected 0", idx_viol); end
        checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL rnd_done_pulse: got %b expected 1", done_now); end
        checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL rnd_done_width: got %b expected 0", done_after); end
    endtask

    task automatic test_block_ready_ignored();
        compute_model(BLK_ABC);
        capture(BLK_ABC, 1'b0, 20);
        checks++; if (pr_seen == 0 || pr_viol != 0) begin errors++; $display("FAIL ign_parser_ready: got %0d high of %0d samples expected 0 high", pr_viol, pr_seen); end
        checks++; if (got_n != 64) begin errors++; $display("FAIL ign_count: got %0d expected 64", got_n); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (got_w[t] !== exp_w[t]) begin errors++; $display("FAIL ign_word[%0d]: got %h expected %h", t, got_w[t], exp_w[t]); end
        end
        checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL ign_done_pulse: got %b expected 1", done_now); end
    endtask

    task automatic test_reset_midstream();
        int cyc;
        int bad_done;
        compute_model(BLK_ABC);
        @(negedge clk);
        block_in = BLK_ABC; block_ready = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
        cyc = 0;
        while (!(w_valid === 1'b1 && w_index === 6'd30) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc >= 200) begin errors++; $display("FAIL rstmid_reach30: got timeout expected index 30"); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL rstmid_w_valid: got %b expected 0", w_valid); end
        checks++; if (parser_ready !== 1'b1) begin errors++; $display("FAIL rstmid_parser_ready: got %b expected 1", parser_ready); end
        checks++; if (w_index !== 6'd0) begin errors++; $display("FAIL rstmid_w_index: got %0d expected 0", w_index); end
        rst = 1'b1;
        w_ready = 1'b0;
        bad_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (block_done !== 1'b0) bad_done++;
            @(negedge clk);
        end
        checks++; if (bad_done != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", bad_done); end
        capture(BLK_ABC, 1'b0, -1);
        checks++; if (got_n != 64) begin errors++; $display("FAIL rstmid_resend_count: got %0d expected 64", got_n); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (got_w[t] !== exp_w[t]) begin errors++; $display("FAIL rstmid_word[%0d]: got %h expected %h", t, got_w[t], exp_w[t]); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        block_in = BLK_ABC; block_ready = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        block_in = BLK_ONES;
        cyc = 0;
        while (!(w_valid === 1'b1 && w_index === 6'd63) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc >= 200) begin errors++; $display("FAIL b2b_reach63: got timeout expected index 63"); end
        checks++; if (w_out !== 32'h12B1EDEB) begin errors++; $display("FAIL b2b_W63: got %h expected 12b1edeb", w_out); end
`ifdef SHA256_SCHED_B2B_EN
        checks++; if (parser_ready !== 1'b1) begin errors++; $display("FAIL b2b_parser_ready_63: got %b expected 1", parser_ready); end
        @(negedge clk);
        checks++; if (w_valid !== 1'b1) begin errors++; $display("FAIL b2b_no_gap_valid: got %b expected 1", w_valid); end
        checks++; if (w_index !== 6'd0) begin errors++; $display("FAIL b2b_next_index: got %0d expected 0", w_index); end
        checks++; if (w_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_next_W0: got %h expected ffffffff", w_out); end
        checks++; if (block_done !== 1'b1) begin errors++; $display("FAIL b2b_done_pulse: got %b expected 1", block_done); end
`else
        checks++; if (parser_ready !== 1'b0) begin errors++; $display("FAIL b2b_parser_ready_63: got %b expected 0", parser_ready); end
        @(negedge clk);
        checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap_valid: got %b expected 0", w_valid); end
        checks++; if (block_done !== 1'b1) begin errors++; $display("FAIL b2b_done_pulse: got %b expected 1", block_done); end
        checks++; if (parser_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap_parser_ready: got %b expected 1", parser_ready); end
        @(negedge clk);
        checks++; if (w_valid !== 1'b1) begin errors++; $display("FAIL b2b_next_valid: got %b expected 1", w_valid); end
        checks++; if (w_index !== 6'd0) begin errors++; $display("FAIL b2b_next_index: got %0d expected 0", w_index); end
        checks++; if (w_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_next_W0: got %h expected ffffffff", w_out); end
`endif
        block_ready = 1'b0; w_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_ones();
        capture(BLK_ZERO, 1'b0, -1);
        checks++; if (got_n != 64) begin errors++; $display("FAIL zero_count: got %0d expected 64", got_n); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (got_w[t] !== 32'h0) begin errors++; $display("FAIL zero_word[%0d]: got %h expected 00000000", t, got_w[t]); end
        end
        compute_model(BLK_ONES);
        capture(BLK_ONES, 1'b1, -1);
        checks++; if (got_n != 64) begin errors++; $display("FAIL ones_count: got %0d expected 64", got_n); end
        checks++; if (got_w[16] !== 32'h203FFFFC) begin errors++; $display("FAIL ones_W16: got %h expected 203ffffc", got_w[16]); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (got_w[t] !== exp_w[t]) begin errors++; $display("FAIL ones_word[%0d]: got %h expected %h", t, got_w[t], exp_w[t]); end
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_random_ready();
        test_block_ready_ignored();
        test_reset_midstream();
        test_back_to_back();
        test_zero_ones();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
